prio_enc_rr_reg: RTL and testbench

//  Parametrised, registered N:log2(N) priority encoder with an optional round-robin mode.
//  It samples a request vector and registers the winning index plus a one-hot grant.

---
 rtl/prio_enc_rr_reg.sv | 100 ++++++++++
 tb/tb_prio_enc_rr_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prio_enc_rr_reg.sv
// prio_enc_rr_reg
//   Registered N:log2(N) priority encoder with optional round-robin arbitration.
//   Each cycle in which the output slot is free (or being consumed) and at
//   least one request is present, the winning request is registered as an
//   encoded index plus a one-hot grant and offered on a valid/ready handshake.
//
// Parameters
//   N   number of request lines (>= 2, need not be a power of two)
//   W   width of the encoded index, derived from N
//   RR  0 = fixed priority (highest index wins), 1 = round-robin
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous reset, active-high
//   req        request vector, bit i = source i requesting
//   out_ready  consumer accepts the current result when high with out_valid
//   out_valid  idx/grant hold a valid winner
//   idx        encoded index of the winner
//   grant      one-hot of the winner
//   pend       combinational OR of req, status only

module prio_enc_rr_reg #(
    parameter int N  = 8,
    parameter int W  = (N > 1) ? $clog2(N) : 1,
    parameter bit RR = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         pend
);

    localparam logic [W-1:0] TOP = W'(N - 1);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] start;
    logic [W-1:0] win_lo;
    logic [W-1:0] win_hi;
    logic         any_lo;
    logic [W-1:0] win_p0;
    logic [N-1:0] grant_p0;
    logic         any_req;
    logic         load;

    assign any_req = |req;
    assign pend    = any_req;
    assign load    = (!out_valid || out_ready) && any_req;

    // Search order is start, start-1, ..., 0, N-1, ..., start+1. Split into the
    // bits at or below start and the bits above it; within each half the
    // highest set index wins, and the lower half takes precedence.
    // Fixed priority is the special case start = N-1.
    assign start = RR ? rr_ptr : TOP;

    always_comb begin
        win_lo = '0;
        win_hi = '0;
        any_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (W'(i) <= start) begin
                    win_lo = W'(i);
                    any_lo = 1'b1;
                end else begin
                    win_hi = W'(i);
                end
            end
        end
    end

    assign win_p0   = any_lo ? win_lo : win_hi;
    assign grant_p0 = {{(N-1){1'b0}}, 1'b1} << win_p0;

    // ---- stage boundary: registered winner and handshake ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            idx       <= '0;
            grant     <= '0;
            rr_ptr    <= TOP;
        end else if (load) begin
            out_valid <= 1'b1;
            idx       <= win_p0;
            grant     <= grant_p0;
            // Last winner drops to lowest priority; wrap goes to N-1, not 2^W-1.
            if (RR) begin
                rr_ptr <= (win_p0 == '0) ? TOP : win_p0 - W'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            grant     <= '0;
        end
    end

endmodule

// File: tb/tb_prio_enc_rr_reg.sv
module tb_prio_enc_rr_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Fixed-priority, N=4
    logic [3:0] req_f   = '0;
    logic       rdy_f   = 1'b1;
    logic       vld_f;
    logic [1:0] idx_f;
    logic [3:0] gnt_f;
    logic       pend_f;

    // Round-robin, N=4
    logic [3:0] req_r   = '0;
    logic       rdy_r   = 1'b1;
    logic       vld_r;
    logic [1:0] idx_r;
    logic [3:0] gnt_r;
    logic       pend_r;

    // Round-robin, N=5
    logic [4:0] req_5   = '0;
    logic       rdy_5   = 1'b1;
    logic       vld_5;
    logic [2:0] idx_5;
    logic [4:0] gnt_5;
    logic       pend_5;

    int errors = 0;
    int checks = 0;

    prio_enc_rr_reg #(.N(4), .RR(1'b0)) u_fix (
        .clk(clk), .rst(rst), .req(req_f), .out_ready(rdy_f),
        .out_valid(vld_f), .idx(idx_f), .grant(gnt_f), .pend(pend_f)
    );

    prio_enc_rr_reg #(.N(4), .RR(1'b1)) u_rr4 (
        .clk(clk), .rst(rst), .req(req_r), .out_ready(rdy_r),
        .out_valid(vld_r), .idx(idx_r), .grant(gnt_r), .pend(pend_r)
    );

    prio_enc_rr_reg #(.N(5), .RR(1'b1)) u_rr5 (
        .clk(clk), .rst(rst), .req(req_5), .out_ready(rdy_5),
        .out_valid(vld_5), .idx(idx_5), .grant(gnt_5), .pend(pend_5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RR/fixed sequence with all requests held
    logic [1:0] seq_rr [5];
    // N=5 alternating sequence
    logic [2:0] seq_5 [4];

    initial begin
        seq_rr[0] = 2'd3; seq_rr[1] = 2'd2; seq_rr[2] = 2'd1; seq_rr[3] = 2'd0; seq_rr[4] = 2'd3;
        seq_5[0]  = 3'd4; seq_5[1]  = 3'd0; seq_5[2]  = 3'd4; seq_5[3]  = 3'd0;

        step(); step();
        rst = 1'b0;
        step();

        // Reset / idle state
        chk("rst_vld", 32'(vld_f), 32'd0);
        chk("rst_idx", 32'(idx_f), 32'd0);
        chk("rst_gnt", 32'(gnt_f), 32'd0);
        chk("idle_pend", 32'(pend_f), 32'd0);
        chk("rst_vld_rr", 32'(vld_r), 32'd0);

        // 1: fixed single request, then drain
        req_f = 4'b0110;
        #1 chk("t1_pend", 32'(pend_f), 32'd1);
        step();
        chk("t1_vld", 32'(vld_f), 32'd1);
        chk("t1_idx", 32'(idx_f), 32'd2);
        chk("t1_gnt", 32'(gnt_f), 32'b0100);
        req_f = 4'b0000;
        step();
        chk("t1_drain_vld", 32'(vld_f), 32'd0);
        chk("t1_drain_idx", 32'(idx_f), 32'd0);
        chk("t1_drain_gnt", 32'(gnt_f), 32'd0);

        // 2: hold while consumer stalls, changed req ignored
        req_f = 4'b1000;
        rdy_f = 1'b0;
        step();
        chk("t2_load_idx", 32'(idx_f), 32'd3);
        req_f = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t2_hold_vld", 32'(vld_f), 32'd1);
            chk("t2_hold_idx", 32'(idx_f), 32'd3);
            chk("t2_hold_gnt", 32'(gnt_f), 32'b1000);
        end
        rdy_f = 1'b1;
        step();
        chk("t2_next_vld", 32'(vld_f), 32'd1);
        chk("t2_next_idx", 32'(idx_f), 32'd0);
        chk("t2_next_gnt", 32'(gnt_f), 32'b0001);
        req_f = 4'b0000;
        step();
        chk("t2_drain_vld", 32'(vld_f), 32'd0);

        // 3: all requesting, RR rotates, fixed stays on 3
        req_f = 4'b1111;
        req_r = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_rr_vld", 32'(vld_r), 32'd1);
            chk("t3_rr_idx", 32'(idx_r), 32'(seq_rr[k]));
            chk("t3_rr_gnt", 32'(gnt_r), 32'(4'b0001 << seq_rr[k]));
            chk("t3_fix_idx", 32'(idx_f), 32'd3);
        end
        req_f = 4'b0000;

        // 4: skip and wrap (pointer is 2 after last winner 3)
        req_r = 4'b0010;
        step();
        chk("t4_w1", 32'(idx_r), 32'd1);
        req_r = 4'b1010;
        step();
        chk("t4_wrap", 32'(idx_r), 32'd3);
        step();
        chk("t4_skip", 32'(idx_r), 32'd1);
        req_r = 4'b0000;
        step();
        chk("t4_drain", 32'(vld_r), 32'd0);

        // 5: N=5 wrap goes to 4, never beyond
        req_5 = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_idx", 32'(idx_5), 32'(seq_5[k]));
            chk("t5_range", 32'(idx_5 < 3'd5), 32'd1);
        end
        req_5 = 5'b00000;
        step();
        chk("t5_drain", 32'(vld_5), 32'd0);

        // 6: async reset during hold, then fresh RR arbitration
        req_r = 4'b0100;
        rdy_r = 1'b0;
        step();
        chk("t6_hold_idx", 32'(idx_r), 32'd2);
        step();
        chk("t6_hold_vld", 32'(vld_r), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_vld", 32'(vld_r), 32'd0);
        chk("t6_rst_idx", 32'(idx_r), 32'd0);
        chk("t6_rst_gnt", 32'(gnt_r), 32'd0);
        step();
        rst = 1'b0;
        req_r = 4'b0011;
        rdy_r = 1'b1;
        step();
        chk("t6_post_vld", 32'(vld_r), 32'd1);
        chk("t6_post_idx", 32'(idx_r), 32'd1);
        chk("t6_post_gnt", 32'(gnt_r), 32'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
